// File: rtl/sram_march_tester.sv
// sram_march_tester: writes a pattern over an address window through the SPI SRAM encoder, reads it back and compares.
// Latency: one encoder request per word op; request is low for >=1 cycle between ops (2 after a read, for the compare).
// Backpressure: waits for mem_initialized and the busy high/low handshake; busy never rising within TIMEOUT_CYCLES ends the run.
// Optional build macro SRAM_TESTER_LFSR_EN: pattern_sel=3 becomes a Galois LFSR instead of ~address.
module sram_march_tester #(
    parameter int WORD_WIDTH     = 16,
    parameter int ADDRESS_WIDTH  = 16,
    parameter int ERR_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     mode_block,
    input  logic [1:0]               pattern_sel,
    input  logic                     stop_on_error,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [ADDRESS_WIDTH:0]   length,
    input  logic [WORD_WIDTH-1:0]    seed,
    output logic                     running,
    output logic                     done,
    output logic                     pass,
    output logic                     timeout,
    output logic [ERR_WIDTH-1:0]     err_count,
    output logic [ADDRESS_WIDTH-1:0] first_err_addr,
    output logic [WORD_WIDTH-1:0]    first_err_data,
    output logic                     mem_request,
    input  logic                     mem_busy,
    input  logic                     mem_initialized,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic                     mem_write_enable,
    output logic [WORD_WIDTH-1:0]    mem_write_data,
    input  logic [WORD_WIDTH-1:0]    mem_read_data
);

    localparam int WW = WORD_WIDTH;
    localparam int AW = ADDRESS_WIDTH;
    localparam int EW = ERR_WIDTH;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_INIT,
        S_XFER_REQ,
        S_XFER_WAIT,
        S_CHECK,
        S_ADV,
        S_DONE
    } state_t;

    state_t          state_q, state_d;

    // run configuration captured at start
    logic            mode_block_q;
    logic [1:0]      psel_q;
    logic            soe_q;
    logic [AW-1:0]   base_q;
    logic [AW:0]     len_q;
    logic [WW-1:0]   seed_q;

    // sequencing state: word index, current op, block-mode phase
    logic [AW:0]     idx_q;
    logic            op_write_q;
    logic            phase_read_q;
    logic            abort_q;
    logic [WW-1:0]   rd_data_q;
    logic [TW-1:0]   tmo_cnt_q;

    // FSM control strobes
    logic            load_cfg;
    logic            cap_rd;
    logic            do_check;
    logic            set_timeout;
    logic            step;

    logic [AW:0]     idx_next;
    logic            idx_last;
    logic            last_op;
    logic            idx_inc;
    logic            phase_switch;
    logic [AW-1:0]   cur_addr;
    logic [WW-1:0]   exp_data;
    logic [WW-1:0]   p3_data;
    logic            mismatch;

    assign idx_next     = idx_q + (AW+1)'(1);
    assign idx_last     = (idx_next == len_q);
    assign cur_addr     = base_q + AW'(idx_q);
    assign mismatch     = (rd_data_q != exp_data);
    assign last_op      = idx_last && (mode_block_q ? phase_read_q : !op_write_q);
    assign phase_switch = step && mode_block_q && !phase_read_q && idx_last;
    assign idx_inc      = step && (mode_block_q ? !phase_switch : !op_write_q);

`ifdef SRAM_TESTER_LFSR_EN
    // Right-shifting Galois masks; only the listed widths are maximal-length.
    function automatic logic [63:0] lfsr_taps(input int w);
        case (w)
            8:       return 64'hB8;
            16:      return 64'hB400;
            24:      return 64'hE10000;
            32:      return 64'h80200003;
            default: return 64'h1 << (w - 1);
        endcase
    endfunction

    localparam logic [WW-1:0] LFSR_TAPS = WW'(lfsr_taps(WW));

    logic [WW-1:0] lfsr_q;

    // LFSR tracks the word index: load at start, step per word, reload when block mode enters the read phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= '0;
        end else if (load_cfg) begin
            lfsr_q <= (seed == '0) ? WW'(1) : seed;
        end else if (phase_switch) begin
            lfsr_q <= (seed_q == '0) ? WW'(1) : seed_q;
        end else if (idx_inc) begin
            lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        end
    end

    assign p3_data = lfsr_q;
`else
    assign p3_data = ~WW'(cur_addr);
`endif

    // expected word for the current index; identical for the write and its later read
    always_comb begin
        exp_data = '0;
        case (psel_q)
            2'd0:    exp_data = seed_q + WW'(idx_q);
            2'd1:    exp_data = WW'(cur_addr);
            2'd2:    exp_data = WW'(1) << (32'(idx_q) % WW);
            default: exp_data = p3_data;
        endcase
    end

    // state register; reset drops the request combinationally through the state decode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state and control strobes
    always_comb begin
        state_d     = state_q;
        load_cfg    = 1'b0;
        cap_rd      = 1'b0;
        do_check    = 1'b0;
        set_timeout = 1'b0;
        step        = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    load_cfg = 1'b1;
                    state_d  = (length == '0) ? S_DONE : S_WAIT_INIT;
                end
            end
            S_WAIT_INIT: begin
                if (abort_q) begin
                    state_d = S_DONE;
                end else if (mem_initialized) begin
                    state_d = S_XFER_REQ;
                end
            end
            S_XFER_REQ: begin
                if (mem_busy) begin
                    state_d = S_XFER_WAIT;
                end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    set_timeout = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_XFER_WAIT: begin
                if (!mem_busy) begin
                    cap_rd  = 1'b1;
                    state_d = op_write_q ? S_ADV : S_CHECK;
                end
            end
            S_CHECK: begin
                do_check = 1'b1;
                state_d  = (mismatch && soe_q) ? S_DONE : S_ADV;
            end
            S_ADV: begin
                if (abort_q || last_op) begin
                    state_d = S_DONE;
                end else begin
                    step    = 1'b1;
                    state_d = S_XFER_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // configuration capture, sequencing counters and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_block_q   <= 1'b0;
            psel_q         <= '0;
            soe_q          <= 1'b0;
            base_q         <= '0;
            len_q          <= '0;
            seed_q         <= '0;
            idx_q          <= '0;
            op_write_q     <= 1'b0;
            phase_read_q   <= 1'b0;
            abort_q        <= 1'b0;
            rd_data_q      <= '0;
            tmo_cnt_q      <= '0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (load_cfg) begin
            mode_block_q   <= mode_block;
            psel_q         <= pattern_sel;
            soe_q          <= stop_on_error;
            base_q         <= base_addr;
            len_q          <= length;
            seed_q         <= seed;
            idx_q          <= '0;
            op_write_q     <= 1'b1;
            phase_read_q   <= 1'b0;
            abort_q        <= 1'b0;
            rd_data_q      <= '0;
            tmo_cnt_q      <= '0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else begin
            if (abort && running) begin
                abort_q <= 1'b1;
            end
            if (state_q == S_XFER_REQ && !mem_busy) begin
                tmo_cnt_q <= tmo_cnt_q + TW'(1);
            end else begin
                tmo_cnt_q <= '0;
            end
            if (cap_rd) begin
                rd_data_q <= mem_read_data;
            end
            if (set_timeout) begin
                timeout <= 1'b1;
            end
            if (do_check && mismatch) begin
                if (err_count != '1) begin
                    err_count <= err_count + EW'(1);
                end
                if (err_count == '0) begin
                    first_err_addr <= cur_addr;
                    first_err_data <= rd_data_q;
                end
            end
            if (phase_switch) begin
                phase_read_q <= 1'b1;
                op_write_q   <= 1'b0;
                idx_q        <= '0;
            end else if (step) begin
                if (idx_inc) begin
                    idx_q <= idx_next;
                end
                if (!mode_block_q) begin
                    op_write_q <= !op_write_q;
                end
            end
        end
    end

    assign running          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done             = (state_q == S_DONE);
    assign pass             = done && (err_count == '0) && !timeout;
    assign mem_request      = (state_q == S_XFER_REQ) || (state_q == S_XFER_WAIT);
    assign mem_write_enable = mem_request && op_write_q;
    assign mem_address      = cur_addr;
    assign mem_write_data   = exp_data;

endmodule

// File: tb/tb_sram_march_tester.sv
// tb_sram_march_tester: drives sram_march_tester against a busy-handshake SRAM model.
// Expected op streams and results come from a word-level model of the march sequence.
// The SRAM model can inject a bit-0 fault at one address or never raise busy.
`timescale 1ns/1ps
module tb_sram_march_tester;
    localparam int WW  = 16;
    localparam int AW  = 16;
    localparam int EW  = 8;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          mode_block = 1'b0;
    logic [1:0]    pattern_sel = 2'd0;
    logic          stop_on_error = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic [WW-1:0] seed = '0;
    logic          running, done, pass, timeout;
    logic [EW-1:0] err_count;
    logic [AW-1:0] first_err_addr;
    logic [WW-1:0] first_err_data;
    logic          mem_request;
    logic          mem_busy = 1'b0;
    logic          mem_initialized = 1'b0;
    logic [AW-1:0] mem_address;
    logic          mem_write_enable;
    logic [WW-1:0] mem_write_data;
    logic [WW-1:0] mem_read_data = '0;

    int errors = 0;
    int checks = 0;

    sram_march_tester #(
        .WORD_WIDTH(WW), .ADDRESS_WIDTH(AW), .ERR_WIDTH(EW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .mode_block(mode_block), .pattern_sel(pattern_sel), .stop_on_error(stop_on_error),
        .base_addr(base_addr), .length(length), .seed(seed),
        .running(running), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .first_err_addr(first_err_addr), .first_err_data(first_err_data),
        .mem_request(mem_request), .mem_busy(mem_busy), .mem_initialized(mem_initialized),
        .mem_address(mem_address), .mem_write_enable(mem_write_enable),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } op_t;

    // ---------------- SRAM model (acts on the falling edge) ----------------
    logic [WW-1:0] sram [0:65535];
    op_t           ops_seen[$];
    int            busy_len = 4;
    bit            never_busy = 0;
    bit            fault_en = 0;
    logic [AW-1:0] fault_addr = '0;
    int            busy_left = 0;
    bit            active = 0;
    int            proto_errs = 0;
    int            req_cycles = 0;

    always @(negedge clk) begin
        if (reset) begin
            mem_busy  = 1'b0;
            active    = 0;
            busy_left = 0;
        end else begin
            if (mem_request) req_cycles++;
            if (mem_busy) begin
                if (!mem_request) proto_errs++;
                busy_left--;
                if (busy_left <= 0) mem_busy = 1'b0;
            end else if (mem_request && !active) begin
                active = 1;
                ops_seen.push_back(op_t'{mem_write_enable, mem_address,
                                         mem_write_enable ? mem_write_data : 16'h0});
                if (!never_busy) begin
                    if (mem_write_enable) sram[mem_address] = mem_write_data;
                    else mem_read_data = sram[mem_address] ^
                             ((fault_en && mem_address == fault_addr) ? 16'h1 : 16'h0);
                    mem_busy  = 1'b1;
                    busy_left = busy_len;
                end
            end else if (!mem_request) begin
                active = 0;
            end
        end
    end

    // ---------------- reference model ----------------
    op_t           exp_ops[$];
    int            exp_errs;
    logic [AW-1:0] exp_first_addr;
    logic [WW-1:0] exp_first_data;

    function automatic logic [WW-1:0] pattern_word(input int p, input logic [WW-1:0] sd,
                                                   input int i, input logic [AW-1:0] a);
        case (p)
            0: return sd + WW'(i);
            1: return a;
            2: return 16'h1 << (i % WW);
            default: begin
`ifdef SRAM_TESTER_LFSR_EN
                logic [WW-1:0] v;
                v = (sd == 16'h0) ? 16'h1 : sd;
                for (int k = 0; k < i; k++) v = (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0);
                return v;
`else
                return ~a;
`endif
            end
        endcase
    endfunction

    task automatic note_read(input logic [AW-1:0] a, input logic [WW-1:0] d,
                             input logic soe, inout bit stop);
        if (fault_en && a == fault_addr) begin
            if (exp_errs == 0) begin
                exp_first_addr = a;
                exp_first_data = d ^ 16'h1;
            end
            if (exp_errs < 255) exp_errs++;
            if (soe) stop = 1;
        end
    endtask

    task automatic build_expected(input logic mb, input int p, input logic [AW-1:0] b,
                                  input int len, input logic [WW-1:0] sd, input logic soe);
        bit stop = 0;
        logic [AW-1:0] a;
        exp_ops.delete();
        exp_errs = 0; exp_first_addr = '0; exp_first_data = '0;
        if (!mb) begin
            for (int i = 0; i < len && !stop; i++) begin
                a = b + AW'(i);
                exp_ops.push_back(op_t'{1'b1, a, pattern_word(p, sd, i, a)});
                exp_ops.push_back(op_t'{1'b0, a, 16'h0});
                note_read(a, pattern_word(p, sd, i, a), soe, stop);
            end
        end else begin
            for (int i = 0; i < len; i++) begin
                a = b + AW'(i);
                exp_ops.push_back(op_t'{1'b1, a, pattern_word(p, sd, i, a)});
            end
            for (int i = 0; i < len && !stop; i++) begin
                a = b + AW'(i);
                exp_ops.push_back(op_t'{1'b0, a, 16'h0});
                note_read(a, pattern_word(p, sd, i, a), soe, stop);
            end
        end
    endtask

    // index of first difference between observed and expected op streams, -1 if none
    function automatic int ops_mismatch(input bit prefix_only);
        if (ops_seen.size() > exp_ops.size()) return exp_ops.size();
        foreach (ops_seen[k]) if (ops_seen[k] !== exp_ops[k]) return k;
        if (!prefix_only && ops_seen.size() != exp_ops.size()) return ops_seen.size();
        return -1;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic start_run(input logic mb, input logic [1:0] p, input logic [AW-1:0] b,
                             input int len, input logic [WW-1:0] sd, input logic soe);
        @(negedge clk);
        mode_block = mb; pattern_sel = p; base_addr = b; length = (AW+1)'(len);
        seed = sd; stop_on_error = soe;
        ops_seen.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit finished);
        finished = 0;
        for (int c = 0; c < budget && !finished; c++) begin
            if (done) finished = 1;
            else @(negedge clk);
        end
    endtask

    task automatic run_cfg(input logic mb, input logic [1:0] p, input logic [AW-1:0] b,
                           input int len, input logic [WW-1:0] sd, input logic soe,
                           output bit finished);
        start_run(mb, p, b, len, sd, soe);
        wait_done(4 * len * (busy_len + 8) + 200, finished);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [63:0] obs;
        obs = {running, done, pass, timeout, err_count, mem_request, mem_write_enable,
               first_err_addr[0], first_err_data[0]};
        checks++;
        if (obs !== 64'h0 || mem_address !== '0 || mem_write_data !== '0 ||
            first_err_addr !== '0 || first_err_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got flags=%h addr=%h wdata=%h fea=%h fed=%h required all 0",
                     obs, mem_address, mem_write_data, first_err_addr, first_err_data);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({running, done, pass, timeout, mem_request} !== 5'b0 || err_count !== '0) begin
            errors++;
            $display("FAIL reset_release: run=%b done=%b pass=%b tmo=%b req=%b err=%0d required 0",
                     running, done, pass, timeout, mem_request, err_count);
        end
    endtask

    task automatic test_interleaved_p0;
        bit fin;
        int rq;
        busy_len = 40;
        mem_initialized = 1'b0;
        build_expected(1'b0, 0, 16'h1536, 4, 16'h650F, 1'b0);
        req_cycles = 0;
        start_run(1'b0, 2'd0, 16'h1536, 4, 16'h650F, 1'b0);
        checks++;
        if (running !== 1'b1) begin
            errors++; $display("FAIL p0_running: got %b required 1", running);
        end
        repeat (20) @(negedge clk);
        rq = req_cycles;
        checks++;
        if (rq !== 0) begin
            errors++; $display("FAIL p0_wait_init: %0d request cycles before init, required 0", rq);
        end
        mem_initialized = 1'b1;
        wait_done(2000, fin);
        checks++;
        if (!fin) begin errors++; $display("FAIL p0_done: no done within budget"); end
        checks++;
        if (ops_mismatch(0) != -1) begin
            errors++; $display("FAIL p0_ops: first diff at %0d, saw %0d ops required %0d",
                               ops_mismatch(0), ops_seen.size(), exp_ops.size());
        end
        checks++;
        if (pass !== 1'b1 || err_count !== '0 || running !== 1'b0 || mem_request !== 1'b0) begin
            errors++; $display("FAIL p0_result: pass=%b err=%0d run=%b req=%b required 1,0,0,0",
                               pass, err_count, running, mem_request);
        end
        checks++;
        if (proto_errs !== 0) begin
            errors++; $display("FAIL p0_protocol: %0d request drops while busy, required 0", proto_errs);
        end
        busy_len = 4;
    endtask

    task automatic test_block_wrap;
        bit fin;
        build_expected(1'b1, 1, 16'hFFFE, 4, 16'h0, 1'b0);
        run_cfg(1'b1, 2'd1, 16'hFFFE, 4, 16'h0, 1'b0, fin);
        checks++;
        if (!fin || ops_mismatch(0) != -1) begin
            errors++; $display("FAIL block_wrap_ops: done=%b diff at %0d, saw %0d required %0d",
                               fin, ops_mismatch(0), ops_seen.size(), exp_ops.size());
        end
        checks++;
        if (pass !== 1'b1) begin
            errors++; $display("FAIL block_wrap_pass: got %b required 1", pass);
        end
    endtask

    task automatic test_fault_continue;
        bit fin;
        fault_en = 1; fault_addr = 16'h0005;
        build_expected(1'b0, 2, 16'h0, 16, 16'h0, 1'b0);
        run_cfg(1'b0, 2'd2, 16'h0, 16, 16'h0, 1'b0, fin);
        checks++;
        if (!fin || ops_mismatch(0) != -1) begin
            errors++; $display("FAIL fault_cont_ops: done=%b saw %0d ops required %0d",
                               fin, ops_seen.size(), exp_ops.size());
        end
        checks++;
        if (err_count !== 8'd1 || first_err_addr !== 16'h0005 || first_err_data !== 16'h0021 || pass !== 1'b0) begin
            errors++; $display("FAIL fault_cont_result: err=%0d addr=%h data=%h pass=%b required 1,0005,0021,0",
                               err_count, first_err_addr, first_err_data, pass);
        end
    endtask

    task automatic test_fault_stop;
        bit fin;
        int n;
        fault_en = 1; fault_addr = 16'h0005;
        build_expected(1'b0, 2, 16'h0, 16, 16'h0, 1'b1);
        run_cfg(1'b0, 2'd2, 16'h0, 16, 16'h0, 1'b1, fin);
        n = ops_seen.size();
        repeat (20) @(negedge clk);
        checks++;
        if (!fin || ops_mismatch(0) != -1 || ops_seen.size() != 12) begin
            errors++; $display("FAIL fault_stop_ops: done=%b saw %0d ops required 12", fin, ops_seen.size());
        end
        checks++;
        if (ops_seen.size() != n || mem_request !== 1'b0) begin
            errors++; $display("FAIL fault_stop_quiet: ops grew %0d->%0d req=%b required no change",
                               n, ops_seen.size(), mem_request);
        end
        checks++;
        if (err_count !== 8'd1 || first_err_data !== 16'h0021 || pass !== 1'b0) begin
            errors++; $display("FAIL fault_stop_result: err=%0d data=%h pass=%b required 1,0021,0",
                               err_count, first_err_data, pass);
        end
        fault_en = 0;
    endtask

    task automatic test_back_to_back;
        bit fin;
        build_expected(1'b0, 0, 16'h0040, 2, 16'h1234, 1'b0);
        start_run(1'b0, 2'd0, 16'h0040, 2, 16'h1234, 1'b0);
        checks++;
        if (err_count !== '0 || done !== 1'b0 || running !== 1'b1 || first_err_addr !== '0 || first_err_data !== '0) begin
            errors++; $display("FAIL b2b_clear: err=%0d done=%b run=%b fea=%h fed=%h required 0,0,1,0,0",
                               err_count, done, running, first_err_addr, first_err_data);
        end
        wait_done(500, fin);
        checks++;
        if (!fin || pass !== 1'b1 || ops_mismatch(0) != -1) begin
            errors++; $display("FAIL b2b_run: done=%b pass=%b saw %0d ops required %0d",
                               fin, pass, ops_seen.size(), exp_ops.size());
        end
    endtask

    task automatic test_timeout;
        bit fin;
        never_busy = 1;
        req_cycles = 0;
        run_cfg(1'b0, 2'd0, 16'h0100, 3, 16'h0, 1'b0, fin);
        checks++;
        if (!fin || req_cycles != TMO) begin
            errors++; $display("FAIL timeout_cycles: done=%b request high %0d cycles required %0d",
                               fin, req_cycles, TMO);
        end
        checks++;
        if (timeout !== 1'b1 || mem_request !== 1'b0 || done !== 1'b1 || pass !== 1'b0 || ops_seen.size() != 1) begin
            errors++; $display("FAIL timeout_result: tmo=%b req=%b done=%b pass=%b ops=%0d required 1,0,1,0,1",
                               timeout, mem_request, done, pass, ops_seen.size());
        end
        never_busy = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_len0;
        bit fin;
        req_cycles = 0;
        run_cfg(1'b0, 2'd0, 16'h0, 0, 16'h0, 1'b0, fin);
        repeat (5) @(negedge clk);
        checks++;
        if (!fin || pass !== 1'b1 || timeout !== 1'b0 || req_cycles != 0) begin
            errors++; $display("FAIL len0: done=%b pass=%b tmo=%b req_cycles=%0d required 1,1,0,0",
                               fin, pass, timeout, req_cycles);
        end
    endtask

    task automatic test_abort;
        bit fin;
        bit got;
        build_expected(1'b0, 1, 16'h0200, 8, 16'h0, 1'b0);
        start_run(1'b0, 2'd1, 16'h0200, 8, 16'h0, 1'b0);
        got = 0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            if (ops_seen.size() >= 3) got = 1;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(300, fin);
        repeat (3) @(negedge clk);
        checks++;
        if (!got || !fin || ops_seen.size() >= exp_ops.size() || ops_seen.size() < 3) begin
            errors++; $display("FAIL abort_end: reached=%b done=%b ops=%0d required done with 3..%0d ops",
                               got, fin, ops_seen.size(), exp_ops.size() - 1);
        end
        checks++;
        if (ops_mismatch(1) != -1 || proto_errs != 0 || mem_request !== 1'b0) begin
            errors++; $display("FAIL abort_prefix: diff at %0d proto=%0d req=%b required clean prefix",
                               ops_mismatch(1), proto_errs, mem_request);
        end
    endtask

    task automatic test_lfsr_p3;
        bit fin;
        logic [WW-1:0] sd;
        build_expected(1'b0, 3, 16'h0100, 6, 16'h0, 1'b0);
        run_cfg(1'b0, 2'd3, 16'h0100, 6, 16'h0, 1'b0, fin);
        checks++;
        if (!fin || pass !== 1'b1 || ops_mismatch(0) != -1) begin
            errors++; $display("FAIL p3_interleaved: done=%b pass=%b diff at %0d", fin, pass, ops_mismatch(0));
        end
        sd = 16'($urandom);
        build_expected(1'b1, 3, 16'h0300, 5, sd, 1'b0);
        run_cfg(1'b1, 2'd3, 16'h0300, 5, sd, 1'b0, fin);
        checks++;
        if (!fin || pass !== 1'b1 || ops_mismatch(0) != -1) begin
            errors++; $display("FAIL p3_block: seed=%h done=%b pass=%b diff at %0d", sd, fin, pass, ops_mismatch(0));
        end
    endtask

    task automatic test_random;
        bit fin;
        logic mb, soe;
        logic [1:0] p;
        logic [AW-1:0] b;
        logic [WW-1:0] sd;
        int len;
        for (int it = 0; it < 14; it++) begin
            mb = 1'($urandom); soe = 1'($urandom); p = 2'($urandom);
            b = 16'($urandom); sd = 16'($urandom);
            len = 1 + $urandom_range(0, 9);
            busy_len = 1 + $urandom_range(0, 4);
            fault_en = 1'($urandom);
            fault_addr = b + AW'($urandom_range(0, len - 1));
            build_expected(mb, int'(p), b, len, sd, soe);
            run_cfg(mb, p, b, len, sd, soe, fin);
            checks++;
            if (!fin || ops_mismatch(0) != -1) begin
                errors++; $display("FAIL rand%0d_ops: mb=%b p=%0d base=%h len=%0d done=%b diff at %0d saw %0d required %0d",
                                   it, mb, p, b, len, fin, ops_mismatch(0), ops_seen.size(), exp_ops.size());
            end
            checks++;
            if (err_count !== EW'(exp_errs) || first_err_addr !== exp_first_addr ||
                first_err_data !== exp_first_data || pass !== (exp_errs == 0)) begin
                errors++; $display("FAIL rand%0d_result: err=%0d/%0d addr=%h/%h data=%h/%h pass=%b (got/required)",
                                   it, err_count, exp_errs, first_err_addr, exp_first_addr,
                                   first_err_data, exp_first_data, pass);
            end
        end
        fault_en = 0;
        busy_len = 4;
    endtask

    task automatic test_reset_mid;
        bit got;
        busy_len = 20;
        start_run(1'b1, 2'd0, 16'h0400, 4, 16'h0, 1'b0);
        got = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (mem_busy) got = 1;
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (!got || mem_request !== 1'b0 || running !== 1'b0) begin
            errors++; $display("FAIL reset_mid: busy_seen=%b req=%b run=%b required 1,0,0", got, mem_request, running);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || mem_request !== 1'b0 || err_count !== '0) begin
            errors++; $display("FAIL reset_mid_idle: done=%b req=%b err=%0d required 0", done, mem_request, err_count);
        end
        busy_len = 4;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        test_interleaved_p0;
        test_block_wrap;
        test_fault_continue;
        test_fault_stop;
        test_back_to_back;
        test_timeout;
        test_len0;
        test_abort;
        test_lfsr_p3;
        test_random;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
